// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg
// Shared definitions for the PLL lock sequencer: the FSM state encoding
// and its width, plus the default timing parameters.
package pll_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef logic [STATE_W-1:0] pll_state_t;

  localparam logic [STATE_W-1:0] ST_HOLD   = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT   = 3'd1;
  localparam logic [STATE_W-1:0] ST_STABLE = 3'd2;
  localparam logic [STATE_W-1:0] ST_RUN    = 3'd3;
  localparam logic [STATE_W-1:0] ST_FAULT  = 3'd4;

  localparam int DEF_RST_CYCLES    = 16;
  localparam int DEF_LOCK_TIMEOUT  = 50000;  // 1 ms at 50 MHz
  localparam int DEF_STABLE_CYCLES = 256;
  localparam int DEF_MAX_RETRIES   = 4;

  // Used to size the one counter shared by every timed state.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer with asynchronous active-low clear.
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low clear of both stages
//   d     - asynchronous input
//   q     - synchronized output (two clk edges of latency)
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= '0;
      sync_reg <= '0;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer
// Sequences a PLL out of reset: pulses pll_rst, waits for lock with a
// timeout, qualifies lock over a run of stable samples, then releases
// sys_rst and raises ready. Repeated timeouts end in a sticky fault.
// Ports:
//   refclk     - free-running reference clock (sole clock)
//   rst_n      - asynchronous active-low reset
//   restart    - one-cycle request to re-run the whole sequence
//   locked     - PLL lock, asynchronous to refclk
//   pll_rst    - active-high reset to the PLL
//   sys_rst    - active-high reset for logic on the PLL output clock
//   ready      - PLL locked and qualified
//   fault      - sticky, all retries timed out
//   retry_cnt  - failed attempts since last RUN entry or restart
//   relock_cnt - loss-of-lock events seen in RUN, saturating
//   state      - current FSM state code
module pll_lock_sequencer
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int MAX_RETRIES   = DEF_MAX_RETRIES
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               restart,
  input  logic               locked,
  output logic               pll_rst,
  output logic               sys_rst,
  output logic               ready,
  output logic               fault,
  output logic [3:0]         retry_cnt,
  output logic [7:0]         relock_cnt,
  output logic [STATE_W-1:0] state
);

  localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  logic lock_s;
  logic rst_rel;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (lock_s)
  );

  // Constant-one input: output rises two edges after rst_n releases, so
  // the HOLD count never starts on a metastable reset release.
  sync_2ff #(.WIDTH(1)) u_rst_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (rst_rel)
  );

  pll_state_t       state_reg,  state_next;
  logic [CNT_W-1:0] cnt_reg,    cnt_next;
  logic [3:0]       retry_reg,  retry_next;
  logic [7:0]       relock_reg, relock_next;
  logic             pll_rst_reg, sys_rst_reg, ready_reg, fault_reg;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    retry_next  = retry_reg;
    relock_next = relock_reg;
    if (restart) begin
      // Overrides timeout and lock loss evaluated in the same cycle.
      state_next = ST_HOLD;
      cnt_next   = '0;
      retry_next = '0;
    end else begin
      case (state_reg)
        ST_HOLD: begin
          if (rst_rel) begin
            if (cnt_reg == RST_LAST) begin
              state_next = ST_WAIT;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (lock_s) begin
            state_next = ST_STABLE;
            cnt_next   = '0;
          end else if (cnt_reg == TIMEOUT_LAST) begin
            retry_next = retry_reg + 4'd1;
            state_next = (retry_next == RETRY_LIMIT) ? ST_FAULT : ST_HOLD;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_next = ST_WAIT;
            cnt_next   = '0;
          end else if (cnt_reg == STABLE_LAST) begin
            state_next = ST_RUN;
            cnt_next   = '0;
            retry_next = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ST_RUN: begin
          if (!lock_s) begin
            state_next = ST_HOLD;
            cnt_next   = '0;
            if (relock_reg != 8'hFF) begin
              relock_next = relock_reg + 8'd1;
            end
          end
        end
        ST_FAULT: begin
          // Parked until restart or rst_n.
        end
        default: begin
          state_next = ST_HOLD;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so they line
  // up with the state register and cannot glitch.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_HOLD;
      cnt_reg     <= '0;
      retry_reg   <= '0;
      relock_reg  <= '0;
      pll_rst_reg <= 1'b1;
      sys_rst_reg <= 1'b1;
      ready_reg   <= 1'b0;
      fault_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      retry_reg   <= retry_next;
      relock_reg  <= relock_next;
      pll_rst_reg <= (state_next == ST_HOLD) || (state_next == ST_FAULT);
      sys_rst_reg <= (state_next != ST_RUN);
      ready_reg   <= (state_next == ST_RUN);
      fault_reg   <= (state_next == ST_FAULT);
    end
  end

  assign pll_rst    = pll_rst_reg;
  assign sys_rst    = sys_rst_reg;
  assign ready      = ready_reg;
  assign fault      = fault_reg;
  assign retry_cnt  = retry_reg;
  assign relock_cnt = relock_reg;
  assign state      = state_reg;

endmodule
